ddr3_dqs_eye_trainer: RTL and testbench
=======================================

DDR3_DQS_EYE_TRAINER -- requirements
Module: ddr3_dqs_eye_trainer

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 16: cycles the eye monitor accumulates after each flag clear.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: idle cycles after each delay-line move or load.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive balanced samples needed to declare lock.
REQ-004 SHALL have parameter MAX_STEPS, default 255: total moves allowed before timeout.
REQ-005 SHALL have parameter INIT_TAP, default 8'd1: tap value restored by a delay-line load.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have port FAB_CLK, input, 1: sole clock.
REQ-008 SHALL have port RESET_N, input, 1: synchronous active-low reset.
REQ-009 SHALL have port START, input, 1: one-cycle request to begin training.
REQ-010 SHALL have port EYE_MONITOR_EARLY, input, 1: lane early flag.
REQ-011 SHALL have port EYE_MONITOR_LATE, input, 1: lane late flag.
REQ-012 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1: delay line at its limit.
REQ-013 SHALL have port DELAY_LINE_MOVE, output, 1: one-cycle step pulse.
REQ-014 SHALL have port DELAY_LINE_DIRECTION, output, 1: step direction; 1 = increment tap, 0 = decrement.
REQ-015 SHALL have port DELAY_LINE_LOAD, output, 1: one-cycle pulse that restores INIT_TAP.
REQ-016 SHALL have port EYE_MONITOR_CLEAR_FLAGS, output, 1: one-cycle flag clear.
REQ-017 SHALL have port TAP_POS, output, 8: tracked tap value.
REQ-018 SHALL have port BUSY, DONE, ERR, output, 1 each: status.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, SETTLE, CLEAR, SAMPLE, DECIDE, MOVE, LOCKED, FAIL.
REQ-020 In IDLE, START SHALL cause a transition to LOAD on the next cycle, and SHALL clear DONE, ERR and the step and lock counters.
REQ-021 START SHALL be ignored in every state other than IDLE, LOCKED and FAIL.
REQ-022 In LOCKED or FAIL, START SHALL restart training exactly as it does from IDLE.
REQ-023 LOAD SHALL last 1 cycle, assert DELAY_LINE_LOAD, set TAP_POS to INIT_TAP, and go to SETTLE.
REQ-024 SETTLE SHALL last SETTLE_CYCLES cycles and then go to CLEAR.
REQ-025 CLEAR SHALL last 1 cycle, assert EYE_MONITOR_CLEAR_FLAGS, and go to SAMPLE.
REQ-026 SAMPLE SHALL last SAMPLE_CYCLES cycles, register EARLY and LATE on its last cycle, and go to DECIDE.
REQ-027 In DECIDE, early-only SHALL result in an increment move.
REQ-028 In DECIDE, late-only SHALL result in a decrement move.
REQ-029 In DECIDE, both-or-neither SHALL increment the lock counter; a move SHALL reset the lock counter to 0.
REQ-030 When the lock counter reaches LOCK_COUNT, DECIDE SHALL go to LOCKED; otherwise, if no move is needed, it SHALL go to CLEAR.
REQ-031 MOVE SHALL last 1 cycle, assert DELAY_LINE_MOVE with DELAY_LINE_DIRECTION valid in the same cycle, update TAP_POS by ±1, increment the step counter, and go to SETTLE.
REQ-032 DELAY_LINE_DIRECTION SHALL hold its last value outside MOVE.
REQ-033 An increment at TAP_POS=255 or a decrement at TAP_POS=0 SHALL go to FAIL with no MOVE pulse; TAP_POS SHALL never wrap.
REQ-034 DELAY_LINE_OUT_OF_RANGE sampled high in DECIDE SHALL go to FAIL, taking precedence over lock.
REQ-035 When the step counter equals MAX_STEPS in DECIDE and a move is needed, the FSM SHALL go to FAIL.
REQ-036 LOCKED SHALL assert DONE; FAIL SHALL assert ERR; both SHALL be held until START or reset.
REQ-037 BUSY SHALL be high in every state except IDLE, LOCKED and FAIL.
REQ-038 All outputs SHALL be registered.
REQ-039 MOVE, LOAD and CLEAR_FLAGS SHALL be mutually exclusive.

Reset
REQ-040 While RESET_N=0 at a FAB_CLK edge, the state SHALL become IDLE.
REQ-041 While RESET_N=0 at a FAB_CLK edge, all pulses SHALL become 0, DIRECTION 0, TAP_POS INIT_TAP, and BUSY/DONE/ERR 0.
REQ-042 While RESET_N=0 at a FAB_CLK edge, all counters SHALL become 0.
REQ-043 A reset mid-training SHALL abort with no further pulses.

Structure
REQ-044 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-045 The SETTLE/SAMPLE cycle count SHALL use one sub-module, ddr3_trn_timer, a loadable down-counter with a zero flag.

Verification
REQ-046 START with EARLY held and LATE held low SHALL produce LOAD; after SETTLE, CLEAR and SAMPLE, MOVE with DIRECTION=1; TAP_POS = 2, 3, ....
REQ-047 EARLY for 3 decisions, then EARLY and LATE both high, SHALL give TAP_POS=4; after 4 balanced decisions, DONE=1, BUSY=0 and no further pulses.
REQ-048 LATE held with INIT_TAP=1 SHALL produce one decrement to 0, then ERR=1 with no second MOVE.
REQ-049 DELAY_LINE_OUT_OF_RANGE=1 while EARLY and LATE are balanced SHALL give ERR, not DONE.
REQ-050 Alternating EARLY/LATE with MAX_STEPS=10 SHALL give ERR after exactly 10 MOVE pulses.
REQ-051 RESET_N=0 during SAMPLE SHALL give state IDLE, TAP_POS=1 and all pulses 0 next cycle; a subsequent START SHALL retrain normally.

Source files
------------

// File: rtl/ddr3_dqs_eye_trainer_pkg.sv
// Shared types and default constants for the DDR3 DQS eye trainer.
package ddr3_dqs_eye_trainer_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD, SETTLE, CLEAR, SAMPLE, DECIDE, MOVE, LOCKED, FAIL
  } trn_state_e;

  localparam int         DEF_SAMPLE_CYCLES = 16;
  localparam int         DEF_SETTLE_CYCLES = 4;
  localparam int         DEF_LOCK_COUNT    = 4;
  localparam int         DEF_MAX_STEPS     = 255;
  localparam logic [7:0] DEF_INIT_TAP      = 8'd1;
  localparam int         TMR_W             = 16;

endpackage

// File: rtl/ddr3_trn_timer.sv
// Loadable down-counter with zero flag; times the SETTLE and SAMPLE windows.
module ddr3_trn_timer #(
  parameter int W = 16
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge gclk) begin
    if (!grst_n)          cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_dqs_eye_trainer.sv
// DQS eye trainer: walks a delay line toward the point where early/late flags balance.
module ddr3_dqs_eye_trainer
  import ddr3_dqs_eye_trainer_pkg::*;
#(
  parameter int         SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int         MAX_STEPS     = DEF_MAX_STEPS,
  parameter logic [7:0] INIT_TAP      = DEF_INIT_TAP
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic [7:0] TAP_POS,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  trn_state_e       state;
  logic             early_q, late_q;
  logic [15:0]      step_cnt;
  logic [7:0]       lock_cnt, lock_nxt;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  assign lock_nxt = lock_cnt + 8'd1;

  // Timer is armed on the cycle before a timed state so its first cycle already counts.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      LOAD, MOVE: begin tmr_load = 1'b1; tmr_val = 16'(SETTLE_CYCLES - 1); end
      CLEAR:      begin tmr_load = 1'b1; tmr_val = 16'(SAMPLE_CYCLES - 1); end
      default: ;
    endcase
  end

  ddr3_trn_timer #(.W(TMR_W)) u_tmr (
    .gclk     (FAB_CLK),
    .grst_n   (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                   <= IDLE;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      TAP_POS                 <= INIT_TAP;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      ERR                     <= 1'b0;
      step_cnt                <= '0;
      lock_cnt                <= '0;
      early_q                 <= 1'b0;
      late_q                  <= 1'b0;
    end else begin
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      case (state)
        IDLE, LOCKED, FAIL: if (START) begin
          state           <= LOAD;
          DELAY_LINE_LOAD <= 1'b1;
          TAP_POS         <= INIT_TAP;
          BUSY            <= 1'b1;
          DONE            <= 1'b0;
          ERR             <= 1'b0;
          step_cnt        <= '0;
          lock_cnt        <= '0;
        end
        LOAD:   state <= SETTLE;
        SETTLE: if (tmr_zero) begin
          state                   <= CLEAR;
          EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
        end
        CLEAR:  state <= SAMPLE;
        SAMPLE: if (tmr_zero) begin
          state   <= DECIDE;
          early_q <= EYE_MONITOR_EARLY;
          late_q  <= EYE_MONITOR_LATE;
        end
        DECIDE: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            state <= FAIL;
            BUSY  <= 1'b0;
            ERR   <= 1'b1;
          end else if (early_q == late_q) begin
            lock_cnt <= lock_nxt;
            if (lock_nxt == 8'(LOCK_COUNT)) begin
              state <= LOCKED;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state                   <= CLEAR;
              EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
            end
          end else begin
            lock_cnt <= '0;
            // Refuse to step past either end of the line rather than wrap.
            if (step_cnt == 16'(MAX_STEPS) || (early_q && TAP_POS == 8'hFF) ||
                (late_q && TAP_POS == 8'h00)) begin
              state <= FAIL;
              BUSY  <= 1'b0;
              ERR   <= 1'b1;
            end else begin
              state                <= MOVE;
              DELAY_LINE_MOVE      <= 1'b1;
              DELAY_LINE_DIRECTION <= early_q;
              TAP_POS              <= early_q ? TAP_POS + 8'd1 : TAP_POS - 8'd1;
              step_cnt             <= step_cnt + 16'd1;
            end
          end
        end
        MOVE:    state <= SETTLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_dqs_eye_trainer.sv
// Randomized bench for ddr3_dqs_eye_trainer with a per-decision reference model.
module tb_ddr3_dqs_eye_trainer;

  localparam int         SC = 4;
  localparam int         STC = 2;
  localparam int         LC = 4;
  localparam int         MS = 10;
  localparam logic [7:0] IT = 8'd1;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N, START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS;
  logic [7:0] TAP_POS;
  logic       BUSY, DONE, ERR;

  int   errs = 0;
  int   checks = 0;
  int   m_tap, m_steps, m_lock;
  logic m_dir = 1'b0;

  ddr3_dqs_eye_trainer #(
    .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(STC), .LOCK_COUNT(LC), .MAX_STEPS(MS), .INIT_TAP(IT)
  ) dut (
    .FAB_CLK(FAB_CLK), .RESET_N(RESET_N), .START(START),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .TAP_POS(TAP_POS), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic tick;
    @(negedge FAB_CLK);
  endtask

  function automatic int pulses();
    return int'(DELAY_LINE_MOVE) + int'(DELAY_LINE_LOAD) + int'(EYE_MONITOR_CLEAR_FLAGS);
  endfunction

  // Flag pattern for decision window k of a given scenario.
  task automatic pick(input int mode, input int k, output logic e, output logic l, output logic o);
    int r;
    o = 1'b0;
    case (mode)
      0: begin e = 1'b1; l = 1'b0; end
      1: begin e = 1'b1; l = (k >= 3); end
      2: begin e = 1'b0; l = 1'b1; end
      3: begin e = 1'b1; l = 1'b1; o = (k == 3); end
      4: begin e = (k % 2 == 0); l = (k % 2 != 0); end
      default: begin
        r = $urandom_range(0, 3);
        e = r[0]; l = r[1];
        o = ($urandom_range(0, 15) == 0);
      end
    endcase
  endtask

  // Outcome classes: 0 move, 1 clear again, 2 locked, 3 fail.
  task automatic train(input int mode, input bit poke, input string name);
    int cyc, obs, exp_ev;
    logic e, l, o;
    START = 1'b1; tick; START = 1'b0;
    checks++;
    if (!(DELAY_LINE_LOAD === 1'b1 && TAP_POS === IT && BUSY === 1'b1 && DONE === 1'b0 && ERR === 1'b0)) begin
      errs++;
      $display("FAIL %s start: load=%b tap=%0d busy=%b done=%b err=%b, want 1 %0d 1 0 0",
               name, DELAY_LINE_LOAD, TAP_POS, BUSY, DONE, ERR, IT);
    end
    m_tap = IT; m_steps = 0; m_lock = 0;
    cyc = 0;
    if (poke) begin START = 1'b1; tick; START = 1'b0; cyc = 1; end
    while (EYE_MONITOR_CLEAR_FLAGS !== 1'b1 && cyc < 30) begin
      tick; cyc++;
      if (DELAY_LINE_LOAD === 1'b1 || DELAY_LINE_MOVE === 1'b1) begin
        errs++; $display("FAIL %s settle: unexpected load/move pulse at cycle %0d", name, cyc);
      end
    end
    checks++;
    if (cyc != STC + 1) begin
      errs++; $display("FAIL %s first_clear: after %0d cycles, want %0d", name, cyc, STC + 1);
      return;
    end
    for (int k = 0; k < 80; k++) begin
      pick(mode, k, e, l, o);
      EYE_MONITOR_EARLY = e; EYE_MONITOR_LATE = l; DELAY_LINE_OUT_OF_RANGE = o;
      if (o) exp_ev = 3;
      else if (e == l) begin
        m_lock++;
        exp_ev = (m_lock == LC) ? 2 : 1;
      end else begin
        m_lock = 0;
        if (m_steps == MS || (e && m_tap == 255) || (l && m_tap == 0)) exp_ev = 3;
        else begin
          exp_ev = 0; m_dir = e; m_tap = e ? m_tap + 1 : m_tap - 1; m_steps++;
        end
      end
      cyc = 0;
      do begin tick; cyc++; end
      while (pulses() == 0 && BUSY === 1'b1 && cyc < 40);
      obs = DELAY_LINE_MOVE ? 0 : EYE_MONITOR_CLEAR_FLAGS ? 1 : DONE ? 2 : ERR ? 3 : 4;
      checks++;
      if (obs != exp_ev || cyc != SC + 2 || pulses() > 1) begin
        errs++;
        $display("FAIL %s window%0d: event=%0d after %0d cycles (pulses=%0d), want event=%0d after %0d",
                 name, k, obs, cyc, pulses(), exp_ev, SC + 2);
        return;
      end
      if (exp_ev == 0) begin
        checks++;
        if (DELAY_LINE_DIRECTION !== m_dir || TAP_POS !== 8'(m_tap)) begin
          errs++; $display("FAIL %s move%0d: dir=%b tap=%0d, want dir=%b tap=%0d",
                           name, m_steps, DELAY_LINE_DIRECTION, TAP_POS, m_dir, m_tap);
        end
        cyc = 0;
        do begin tick; cyc++; end
        while (EYE_MONITOR_CLEAR_FLAGS !== 1'b1 && pulses() == 0 && cyc < 30);
        checks++;
        if (EYE_MONITOR_CLEAR_FLAGS !== 1'b1 || cyc != STC + 1 || pulses() > 1) begin
          errs++; $display("FAIL %s resettle: clear=%b after %0d cycles, want 1 after %0d",
                           name, EYE_MONITOR_CLEAR_FLAGS, cyc, STC + 1);
          return;
        end
      end else if (exp_ev >= 2) begin
        EYE_MONITOR_EARLY = 1'b0; EYE_MONITOR_LATE = 1'b0; DELAY_LINE_OUT_OF_RANGE = 1'b0;
        checks++;
        if (DONE !== (exp_ev == 2) || ERR !== (exp_ev == 3) || BUSY !== 1'b0 ||
            TAP_POS !== 8'(m_tap) || DELAY_LINE_DIRECTION !== m_dir) begin
          errs++; $display("FAIL %s end: done=%b err=%b busy=%b tap=%0d dir=%b, want %b %b 0 %0d %b",
                           name, DONE, ERR, BUSY, TAP_POS, DELAY_LINE_DIRECTION,
                           exp_ev == 2, exp_ev == 3, m_tap, m_dir);
        end
        for (int h = 0; h < 5; h++) begin
          tick;
          checks++;
          if (pulses() != 0 || DONE !== (exp_ev == 2) || ERR !== (exp_ev == 3) || BUSY !== 1'b0) begin
            errs++; $display("FAIL %s hold%0d: pulses=%0d done=%b err=%b busy=%b", name, h, pulses(), DONE, ERR, BUSY);
          end
        end
        return;
      end
    end
    errs++; $display("FAIL %s bound: no terminal state within window budget", name);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; START = 1'b0;
    EYE_MONITOR_EARLY = 1'b0; EYE_MONITOR_LATE = 1'b0; DELAY_LINE_OUT_OF_RANGE = 1'b0;
    repeat (3) tick;
    checks++;
    if (pulses() != 0 || DELAY_LINE_DIRECTION !== 1'b0 || TAP_POS !== IT || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      errs++; $display("FAIL reset: pulses=%0d dir=%b tap=%0d busy=%b done=%b err=%b, want 0 0 %0d 0 0 0",
                       pulses(), DELAY_LINE_DIRECTION, TAP_POS, BUSY, DONE, ERR, IT);
    end
    RESET_N = 1'b1;
    repeat (3) tick;
    checks++;
    if (pulses() != 0 || BUSY !== 1'b0) begin
      errs++; $display("FAIL idle: pulses=%0d busy=%b, want 0 0", pulses(), BUSY);
    end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    START = 1'b1; tick; START = 1'b0;
    while (EYE_MONITOR_CLEAR_FLAGS !== 1'b1 && cyc < 30) begin tick; cyc++; end
    EYE_MONITOR_EARLY = 1'b1; EYE_MONITOR_LATE = 1'b0;
    repeat (2) tick;
    RESET_N = 1'b0;
    tick;
    checks++;
    if (pulses() != 0 || BUSY !== 1'b0 || TAP_POS !== IT || DONE !== 1'b0 || ERR !== 1'b0 || DELAY_LINE_DIRECTION !== 1'b0) begin
      errs++; $display("FAIL reset_mid: pulses=%0d busy=%b tap=%0d done=%b err=%b dir=%b, want 0 0 %0d 0 0 0",
                       pulses(), BUSY, TAP_POS, DONE, ERR, DELAY_LINE_DIRECTION, IT);
    end
    m_dir = 1'b0;
    tick; RESET_N = 1'b1;
    for (int h = 0; h < 12; h++) begin
      tick;
      checks++;
      if (pulses() != 0 || BUSY !== 1'b0) begin
        errs++; $display("FAIL reset_quiet%0d: pulses=%0d busy=%b, want 0 0", h, pulses(), BUSY);
      end
    end
    train(1, 1'b0, "retrain");
  endtask

  initial begin
    test_reset;
    train(0, 1'b0, "early_ramp");
    train(1, 1'b0, "lock");
    train(2, 1'b0, "late_floor");
    train(3, 1'b0, "oor_over_lock");
    train(4, 1'b0, "max_steps");
    train(1, 1'b1, "start_ignored");
    for (int i = 0; i < 8; i++) train(5, 1'b0, "random");
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
